// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the 5-stage pipeline: hazard decode, data-memory
// handshake with timeout, debug halt/drain/single-step and performance counters.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  input  logic             wb_valid,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_req,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {RUN, MEM_WAIT, HALTING, HALTED, STEP} state_t;

  state_t        state, ret_state, eff_state, nxt_state;
  logic [DW-1:0] drain_cnt, nxt_drain;
  logic [TW-1:0] wait_cnt;
  logic          active, freeze, hazard, branch, load_use;

  // On the ack cycle of a memory wait the pipeline behaves as in the state it came from.
  always_comb begin
    eff_state = (state == MEM_WAIT) ? ret_state : state;
    active    = (state == RUN) || (state == HALTING) || (state == STEP);
    freeze    = (active && mem_access && !mem_ack) || ((state == MEM_WAIT) && !mem_ack);
    hazard    = ex_memread && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    branch    = !freeze && ex_branch_taken && (eff_state != HALTED);
    load_use  = !freeze && !ex_branch_taken && hazard &&
                ((eff_state == RUN) || (eff_state == STEP));
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_req      = 1'b0;
    halted       = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else begin
      mem_req = (state == MEM_WAIT) || ((state != HALTED) && mem_access);
      halted  = (state == HALTED);
      if (freeze || (eff_state == HALTED)) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end else if (eff_state == HALTING) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = branch;
      end else if (branch) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Progression of the effective state on a non-frozen cycle.
  always_comb begin
    nxt_state = eff_state;
    nxt_drain = drain_cnt;
    case (eff_state)
      RUN: begin
        if (dbg_halt && (state == RUN)) begin
          nxt_state = HALTING;
          nxt_drain = DW'(DRAIN_CYCLES);
        end
      end
      HALTING: begin
        if (drain_cnt <= DW'(1)) begin
          nxt_state = HALTED;
          nxt_drain = '0;
        end else begin
          nxt_drain = drain_cnt - DW'(1);
        end
      end
      STEP: begin
        if (!load_use) begin
          nxt_state = HALTING;
          nxt_drain = DW'(DRAIN_CYCLES);
        end
      end
      HALTED: begin
        if (dbg_resume)    nxt_state = RUN;
        else if (dbg_step) nxt_state = STEP;
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      ret_state    <= RUN;
      drain_cnt    <= '0;
      wait_cnt     <= '0;
      mem_error    <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (wb_valid && mem_wb_write) retire_count <= retire_count + CNT_W'(1);
      if (freeze || load_use)       stall_count  <= stall_count + CNT_W'(1);
      if (branch)                   flush_count  <= flush_count + CNT_W'(1);

      if ((state == MEM_WAIT) && !mem_ack) begin
        if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
          state     <= HALTED;
          mem_error <= 1'b1;
          wait_cnt  <= '0;
        end else begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end else if (freeze) begin
        // A halt request arriving on a stalled RUN cycle is kept as the return state.
        state    <= MEM_WAIT;
        wait_cnt <= '0;
        if ((state == RUN) && dbg_halt) begin
          ret_state <= HALTING;
          drain_cnt <= DW'(DRAIN_CYCLES);
        end else begin
          ret_state <= state;
        end
      end else begin
        state     <= nxt_state;
        drain_cnt <= nxt_drain;
        wait_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int DRAIN = 4;
  localparam int TMO   = 16;
  localparam int CW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
  logic          mem_access, mem_ack, wb_valid, dbg_halt, dbg_step, dbg_resume;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic          if_id_flush, id_ex_flush, mem_req, halted, mem_error;
  logic [CW-1:0] cycle_count, retire_count, stall_count, flush_count;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_req(mem_req), .halted(halted), .mem_error(mem_error),
    .cycle_count(cycle_count), .retire_count(retire_count),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the debug mode (draining / stepping / halted / running) is held in
  // separate flags and a memory wait is an overlay that leaves the mode untouched.
  bit            in_wait, halted_m, step_m, err_m;
  int            waited, drain_left;
  logic [CW-1:0] cyc_m, ret_m, stl_m, fl_m;

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memread = 0; ex_branch_taken = 0;
    mem_access = 0; mem_ack = 0; wb_valid = 0;
    dbg_halt = 0; dbg_step = 0; dbg_resume = 0;
  endtask

  task automatic model_reset();
    in_wait = 0; halted_m = 0; step_m = 0; err_m = 0;
    waited = 0; drain_left = 0;
    cyc_m = '0; ret_m = '0; stl_m = '0; fl_m = '0;
  endtask

  // Inputs are set at the falling edge; compare 1 time unit later, then advance the model.
  task automatic tick();
    int mode;  // 0 running, 1 draining, 2 halted, 3 stepping
    bit hz, frz, br, lu, from_wait;
    bit [4:0] ew;
    bit [1:0] ef;
    bit er, eh;
    #1;
    mode = (drain_left > 0) ? 1 : step_m ? 3 : halted_m ? 2 : 0;
    hz  = ex_memread && (ex_rd != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    frz = in_wait ? !mem_ack : (mode != 2 && mem_access && !mem_ack);
    br  = !frz && ex_branch_taken && mode != 2;
    lu  = !frz && !ex_branch_taken && hz && (mode == 0 || mode == 3);
    if (reset) begin
      ew = 5'b00000; ef = 2'b11; er = 0; eh = 0;
    end else begin
      er = in_wait ? 1'b1 : (mode == 2 ? 1'b0 : mem_access);
      eh = (mode == 2) && !in_wait;
      if (frz || mode == 2) begin ew = 5'b00000; ef = 2'b00; end
      else if (mode == 1)   begin ew = 5'b01111; ef = {1'b1, br}; end
      else if (br)          begin ew = 5'b11111; ef = 2'b11; end
      else if (lu)          begin ew = 5'b00111; ef = 2'b01; end
      else                  begin ew = 5'b11111; ef = 2'b00; end
    end
    chk("writes", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, ew);
    chk("flushes", {if_id_flush, id_ex_flush}, ef);
    chk("mem_req", mem_req, er);
    chk("halted", halted, eh);
    chk("mem_error", mem_error, err_m);
    chk("cycle_count", cycle_count, cyc_m);
    chk("retire_count", retire_count, ret_m);
    chk("stall_count", stall_count, stl_m);
    chk("flush_count", flush_count, fl_m);
    if (reset) begin
      model_reset();
    end else begin
      cyc_m++;
      if (wb_valid && ew[0]) ret_m++;
      if (frz || lu) stl_m++;
      if (br) fl_m++;
      if (in_wait && !mem_ack) begin
        waited++;
        if (waited == TMO) begin
          in_wait = 0; err_m = 1; drain_left = 0; step_m = 0; halted_m = 1;
        end
      end else if (frz) begin
        in_wait = 1; waited = 0;
        if (mode == 0 && dbg_halt) drain_left = DRAIN;
      end else begin
        from_wait = in_wait;
        in_wait = 0;
        case (mode)
          1: begin drain_left--; if (drain_left == 0) halted_m = 1; end
          3: if (!lu) begin step_m = 0; drain_left = DRAIN; end
          2: begin
            if (dbg_resume)    halted_m = 0;
            else if (dbg_step) begin halted_m = 0; step_m = 1; end
          end
          default: if (dbg_halt && !from_wait) drain_left = DRAIN;
        endcase
      end
    end
    @(negedge clock);
  endtask

  task automatic load_use_pair(input logic [4:0] rd);
    clr();
    ex_memread = 1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1; id_rs2 = 5'd2; id_uses_rs2 = 1;
  endtask

  initial begin
    reset = 1;
    clr();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    tick();
    chk("rst_cycle", cycle_count, 0);
    reset = 0;

    load_use_pair(5'd5); tick();
    chk("lu_stall", stall_count, 1);
    load_use_pair(5'd0); tick();
    chk("x0_nostall", stall_count, 1);
    load_use_pair(5'd5); ex_branch_taken = 1; tick();
    chk("br_flush", flush_count, 1);
    chk("br_nostall", stall_count, 1);

    clr(); mem_access = 1; mem_ack = 0;
    tick(); tick(); tick();
    mem_ack = 1; tick();
    chk("mem3_stall", stall_count, 4);
    tick();
    chk("mem0_stall", stall_count, 4);

    clr(); wb_valid = 1; dbg_halt = 1; tick();
    dbg_halt = 0; tick(); tick(); tick();
    chk("halt_early", halted, 0);
    tick();
    chk("halt_lat", halted, 1);
    chk("retire_drain", retire_count, 5);
    tick(); tick(); tick();
    chk("retire_frozen", retire_count, 5);

    clr(); dbg_step = 1; tick();
    dbg_step = 0; tick();
    tick(); tick(); tick();
    chk("step_early", halted, 0);
    wb_valid = 1; tick();
    chk("step_halt", halted, 1);
    chk("step_retire", retire_count, 6);

    clr(); dbg_resume = 1; dbg_step = 1; tick();
    clr();
    chk("resume", halted, 0);

    mem_access = 1; mem_ack = 0; tick();
    repeat (15) tick();
    chk("tmo_early", mem_error, 0);
    tick();
    chk("tmo_err", mem_error, 1);
    chk("tmo_halt", halted, 1);
    clr(); dbg_resume = 1; tick();
    clr(); tick();
    chk("err_sticky", mem_error, 1);

    dbg_halt = 1; tick();
    clr(); tick(); tick();
    reset = 1; tick();
    reset = 0;
    chk("rst_halting", halted, 0);
    chk("rst_err", mem_error, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_retire", retire_count, 0);
    mem_access = 1; mem_ack = 1; tick();

    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_memread      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_access      = ($urandom_range(0, 3) == 0);
      mem_ack         = ($urandom_range(0, 9) < 7);
      wb_valid        = 1'($urandom_range(0, 1));
      dbg_halt        = ($urandom_range(0, 19) == 0);
      dbg_step        = ($urandom_range(0, 9) == 0);
      dbg_resume      = ($urandom_range(0, 14) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage RISC-V pipeline datapath. It decodes hazards (load-use, taken branch), runs the request/acknowledge handshake to a variable-latency data memory, and implements debug halt/drain/single-step. It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps performance counters.

## Interface
- DRAIN_CYCLES, 4: bubbles injected when halting (pipeline depth minus one)
- MEM_TIMEOUT, 16: cycles in MEM_WAIT before a memory error is declared
- CNT_W, 32: width of each performance counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_access  in  1  instruction in MEM is a load or store
- mem_ack  in  1  data memory completes the access this cycle
- wb_valid  in  1  non-bubble instruction in WB
- dbg_halt, dbg_step, dbg_resume  in  1 each  single-cycle debug pulses
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register enables
- if_id_flush, id_ex_flush  out  1 each  load a bubble into that register
- mem_req  out  1  data memory request
- halted  out  1  state is HALTED
- mem_error  out  1  sticky memory timeout flag
- cycle_count, retire_count, stall_count, flush_count  out  CNT_W each

## Operation
- States: RUN, MEM_WAIT, HALTING, HALTED, STEP. Reset state RUN; all counters, mem_error and the drain/timeout counters are 0.
- While reset is high: every *_write = 0, both flushes = 1, mem_req = 0, halted = 0.
- Freeze: all five *_write = 0 and both flushes = 0. Freeze takes priority over every other rule.
- mem_req = mem_access in RUN, HALTING and STEP; it is 1 in MEM_WAIT and 0 in HALTED.
- Memory: mem_access = 1 and mem_ack = 0 in RUN, HALTING or STEP causes a freeze and a move to MEM_WAIT. The return state is remembered.
- MEM_WAIT: freeze and count cycles. When mem_ack = 1, the pipeline advances normally that cycle and the controller returns to the remembered state. When the count reaches MEM_TIMEOUT without an ack, mem_error is set and the controller goes to HALTED.
- Taken branch, when not frozen: if_id_flush = 1, id_ex_flush = 1, all writes = 1. It overrides load-use.
- Load-use, when not frozen and not a branch: the condition is ex_memread && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)). Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1, and the other writes = 1.
- Otherwise all writes = 1 and flushes = 0.
- dbg_halt in RUN goes to HALTING and loads the drain counter with DRAIN_CYCLES.
- HALTING: pc_write = 0, if_id_flush = 1, the other stages advance. The counter decrements only on non-frozen cycles. At 0 the controller goes to HALTED.
- A taken branch during HALTING still flushes ID/EX.
- HALTED: all writes = 0, flushes = 0, halted = 1.
  - dbg_resume goes to RUN.
  - dbg_step goes to STEP. If both arrive together, dbg_resume wins.
- STEP: behaves like one RUN cycle. On a non-frozen, non-stalled cycle it goes to HALTING with a reloaded counter. On a load-use stall it stays in STEP.
- Debug pulses outside the states listed above are ignored.
- Counters wrap modulo 2^CNT_W:
  - cycle_count increments every cycle after reset.
  - retire_count increments when wb_valid && mem_wb_write.
  - stall_count increments on any freeze or load-use cycle.
  - flush_count increments on taken-branch flushes.
- mem_error is cleared only by reset.

## Timing
- Hazard, flush and freeze outputs are combinational from the current state and inputs, with zero latency. State and counters are registered.
- A zero-wait memory (mem_ack in the same cycle as mem_req) adds 0 stall cycles. Each cycle of ack delay adds exactly 1 frozen cycle.
- A load-use stall costs exactly 1 cycle. A taken branch costs 2 bubbles.
- Halt latency: dbg_halt to halted = DRAIN_CYCLES + 1 cycles plus any frozen cycles in between.
- A step cycle reaches halted again DRAIN_CYCLES + 1 cycles after the STEP cycle.
- Asserting reset in any state returns the controller to RUN on the next edge, discarding the drain count and any pending memory wait.

## Test plan
- `lw x5,0(x1); add x6,x5,x2` -> one cycle with pc_write = 0 and id_ex_flush = 1; stall_count = 1. The same pair with rd = x0 -> no stall.
- Taken `beq` in EX in the same cycle as a load-use condition -> if_id_flush = id_ex_flush = 1, pc_write = 1; flush_count +1, stall_count unchanged.
- Load in MEM with mem_ack delayed 3 cycles -> 3 frozen cycles with mem_req held at 1; the pipeline advances on the ack cycle; stall_count = 3.
- mem_ack never asserted -> mem_error = 1 and halted = 1 after 16 cycles in MEM_WAIT.
- dbg_halt in RUN -> halted after 5 cycles with retire_count frozen. dbg_step -> retire_count +1 once the instruction drains. dbg_resume -> RUN.
- Reset asserted during HALTING -> next cycle state is RUN and all counters are 0.
